tone_generator: RTL and testbench

- Sits directly downstream of the 12 MHz frequency selector and consumes its 8-bit divider code `freq_i`.
- The code is the number of clocks per 1/256 of an audio period, so a tone period is 256*`freq_i` clocks.
- Plays each requested note for a fixed duration, followed by a silent gap.
- Produces an 8-bit waveform sample and a 1-bit PWM speaker drive.

---
 rtl/sound_pkg.sv | 40 ++++
 rtl/pwm_dac.sv | 25 ++
 rtl/tone_generator.sv | 138 +++++++++++++
 tb/tb_tone_generator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types, note codes and waveform shaping for the tone generator.
// Imported by tone_generator and pwm_dac.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    WAVE_SQUARE,
    WAVE_SAW,
    WAVE_TRI
  } wave_t;

  localparam logic [7:0] NOTE_A  = 8'd107;
  localparam logic [7:0] NOTE_DS = 8'd151;
  localparam logic [7:0] NOTE_C  = 8'd179;

  localparam int NOTE_CYCLES_DEF = 1_200_000;
  localparam int GAP_CYCLES_DEF  = 120_000;

  // Select 11 falls through to square.
  function automatic logic [7:0] wave_sample(
    input logic [1:0] sel,
    input logic [7:0] ph
  );
    logic [7:0] ramp;
    logic [7:0] s;
    ramp = {ph[6:0], 1'b0};
    unique case (1'b1)
      (sel == WAVE_SAW): s = ph;
      (sel == WAVE_TRI): s = ph[7] ? ~ramp : ramp;
      default:           s = {8{ph[7]}};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC: free-running counter compared against duty_i.
// Ports: clk, nRst (async low), duty_i[7:0], pwm_o (registered).
module pwm_dac (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] duty_i,
  output logic       pwm_o
);

  logic [7:0] pwm_cnt;
  logic       pwm_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pwm_cnt <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_q   <= pwm_cnt < duty_i;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/tone_generator.sv
// Note player: timed tone from a divider code, then a silent gap.
// Ports: clk, nRst, en_i, freq_i, wave_sel_i -> playing_o, sample_o, pwm_o.
module tone_generator
  import sound_pkg::*;
#(
  parameter int NOTE_CYCLES = NOTE_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       en_i,
  input  logic [7:0] freq_i,
  input  logic [1:0] wave_sel_i,
  output logic       playing_o,
  output logic [7:0] sample_o,
  output logic       pwm_o
);

  localparam int DUR_MAX =
    (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int DW = $clog2(DUR_MAX);
  localparam logic [DW-1:0] NOTE_END = DW'(NOTE_CYCLES - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [7:0]    note_q, note_d;
  logic [7:0]    div_cnt, div_d;
  logic [7:0]    phase, phase_d;
  logic [DW-1:0] dur_cnt, dur_d;
  logic [7:0]    sample_q;
  logic          playing_q;

  logic req;
  logic retrig;
  logic div_wrap;

  assign req      = freq_i != 8'd0;
  assign retrig   = req && (freq_i != note_q);
  assign div_wrap = div_cnt == (note_q - 8'd1);

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    div_d   = div_cnt;
    phase_d = phase;
    dur_d   = dur_cnt;
    if (!en_i) begin
      state_d = IDLE;
      div_d   = '0;
      phase_d = '0;
      dur_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_d = PLAY;
            note_d  = freq_i;
            div_d   = '0;
            phase_d = '0;
            dur_d   = '0;
          end
        end
        PLAY: begin
          // A new code restarts the note before note-end is looked at.
          if (retrig) begin
            note_d  = freq_i;
            div_d   = '0;
            phase_d = '0;
            dur_d   = '0;
          end else if (dur_cnt == NOTE_END) begin
            state_d = GAP;
            dur_d   = '0;
          end else begin
            dur_d = dur_cnt + DW'(1);
            if (div_wrap) begin
              div_d   = '0;
              phase_d = phase + 8'd1;
            end else begin
              div_d = div_cnt + 8'd1;
            end
          end
        end
        GAP: begin
          if (dur_cnt == GAP_END) begin
            state_d = IDLE;
            dur_d   = '0;
          end else begin
            dur_d = dur_cnt + DW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          dur_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      note_q  <= '0;
      div_cnt <= '0;
      phase   <= '0;
      dur_cnt <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      div_cnt <= div_d;
      phase   <= phase_d;
      dur_cnt <= dur_d;
    end
  end

  // Outputs trail the state/phase registers by one clock.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sample_q  <= '0;
      playing_q <= 1'b0;
    end else begin
      playing_q <= state_q == PLAY;
      sample_q  <= (state_q == PLAY)
                 ? wave_sample(wave_sel_i, phase)
                 : 8'h00;
    end
  end

  pwm_dac u_pwm (
    .clk    (clk),
    .nRst   (nRst),
    .duty_i (sample_q),
    .pwm_o  (pwm_o)
  );

  assign playing_o = playing_q;
  assign sample_o  = sample_q;

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator with a time-based reference model.
// Also drives a standalone pwm_dac for duty-count checks.
module tb_tone_generator;

  localparam int NOTE = 1000;
  localparam int GAP  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] freq = 8'd0;
  logic [1:0] sel = 2'd0;
  logic       playing;
  logic [7:0] sample;
  logic       pwm;
  logic [7:0] duty = 8'd0;
  logic       pwm_ref;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tone_generator #(
    .NOTE_CYCLES (NOTE),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk        (clk),
    .nRst       (rst_n),
    .en_i       (en),
    .freq_i     (freq),
    .wave_sel_i (sel),
    .playing_o  (playing),
    .sample_o   (sample),
    .pwm_o      (pwm)
  );

  pwm_dac u_pwm_ref (
    .clk    (clk),
    .nRst   (rst_n),
    .duty_i (duty),
    .pwm_o  (pwm_ref)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_wave(
    input logic [1:0] s,
    input logic [7:0] p
  );
    int q;
    q = int'(p);
    if (s == 2'd1) return p;
    if (s == 2'd2) return 8'(q < 128 ? 2 * q : 255 - 2 * (q - 128));
    return (q >= 128) ? 8'hFF : 8'h00;
  endfunction

  typedef struct packed {
    logic       play;
    logic [7:0] samp;
    logic       pwm;
  } exp_t;

  exp_t sb_q[$];

  // Model: phase derived from time since note start, not a divider.
  int         m_st, m_t, m_g;
  logic [7:0] m_note, m_cnt, m_samp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st   <= 0;
      m_t    <= 0;
      m_g    <= 0;
      m_note <= 8'd0;
      m_cnt  <= 8'd0;
      m_samp <= 8'd0;
      sb_q.delete();
    end else begin
      exp_t e;
      e.play = (m_st == 1);
      e.samp = 8'h00;
      if (m_st == 1)
        e.samp = ref_wave(sel, 8'((m_t / int'(m_note)) % 256));
      e.pwm = m_cnt < m_samp;
      sb_q.push_back(e);
      m_cnt  <= m_cnt + 8'd1;
      m_samp <= e.samp;
      if (!en) begin
        m_st <= 0;
      end else if (m_st == 0) begin
        if (freq != 8'd0) begin
          m_st   <= 1;
          m_note <= freq;
          m_t    <= 0;
        end
      end else if (m_st == 1) begin
        if (freq != 8'd0 && freq != m_note) begin
          m_note <= freq;
          m_t    <= 0;
        end else if (m_t == NOTE - 1) begin
          m_st <= 2;
          m_g  <= 0;
        end else begin
          m_t <= m_t + 1;
        end
      end else begin
        if (m_g == GAP - 1) m_st <= 0;
        else m_g <= m_g + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_play", int'(playing), int'(e.play));
      check("sb_samp", int'(sample), int'(e.samp));
      check("sb_pwm", int'(pwm), int'(e.pwm));
    end
  end

  task automatic wait_rise(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!playing && n < 5000);
  endtask

  task automatic run_high(
    input  int         k1,
    input  logic [7:0] f1,
    input  int         k2,
    input  logic [7:0] f2,
    output int         len,
    output logic [7:0] s512,
    output logic [7:0] s513
  );
    len  = 1;
    s512 = 8'd0;
    s513 = 8'd0;
    while (len < 5000) begin
      if (len == 512) s512 = sample;
      if (len == 513) s513 = sample;
      if (len == k1) freq = f1;
      if (len == k2) freq = f2;
      @(negedge clk);
      if (!playing) break;
      len++;
    end
  endtask

  task automatic count_pwm(output int hi);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_ref) hi++;
    end
  endtask

  initial begin
    int n, len, hi, rises, err;
    logic [7:0] s0, s1;

    en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_play", int'(playing), 0);
    check("rst_samp", int'(sample), 0);
    check("rst_pwm", int'(pwm), 0);
    rst_n = 1'b1;
    rises = 0;
    repeat (500) begin
      @(negedge clk);
      if (playing || sample != 8'd0) rises++;
    end
    check("idle_quiet", rises, 0);

    duty = 8'h80;
    repeat (3) @(negedge clk);
    count_pwm(hi);
    check("pwm_80", hi, 128);
    duty = 8'hFF;
    repeat (3) @(negedge clk);
    count_pwm(hi);
    check("pwm_ff", hi, 255);
    duty = 8'h00;
    repeat (3) @(negedge clk);
    count_pwm(hi);
    check("pwm_00", hi, 0);

    sel  = 2'd0;
    freq = 8'd4;
    wait_rise(n);
    check("sq_rise", n, 2);
    run_high(0, 8'd0, 0, 8'd0, len, s0, s1);
    check("sq_len", len, NOTE);
    check("sq_s512", int'(s0), 8'h00);
    check("sq_s513", int'(s1), 8'hFF);
    // Gap plus the single IDLE clock before the held request replays.
    wait_rise(n);
    check("sq_gap", n, GAP + 1);

    run_high(401, 8'd2, 0, 8'd0, len, s0, s1);
    check("rt_len", len, 401 + NOTE + 1);
    wait_rise(n);
    check("rt_gap", n, GAP + 1);

    run_high(200, 8'd2, 500, 8'd0, len, s0, s1);
    check("hold_len", len, NOTE);
    rises = 0;
    repeat (400) begin
      @(negedge clk);
      if (playing) rises++;
    end
    check("hold_idle", rises, 0);

    sel  = 2'd1;
    freq = 8'd1;
    wait_rise(n);
    check("saw_rise", n, 2);
    err = 0;
    for (int k = 1; k <= 600; k++) begin
      if (k <= 300 && sample != 8'(k - 1)) err++;
      if (k == 384) check("tri_7f", int'(sample), 8'hFE);
      if (k == 385) check("tri_80", int'(sample), 8'hFF);
      if (k == 300) sel = 2'd2;
      if (k == 600) en = 1'b0;
      @(negedge clk);
    end
    check("saw_ramp", err, 0);
    @(negedge clk);
    check("en_play", int'(playing), 0);
    check("en_samp", int'(sample), 0);

    en = 1'b1;
    wait_rise(n);
    check("re_rise", n, 2);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_play", int'(playing), 0);
    check("arst_samp", int'(sample), 0);
    check("arst_pwm", int'(pwm), 0);
    freq = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    repeat (100) begin
      @(negedge clk);
      if (playing) rises++;
    end
    check("arst_idle", rises, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
